seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter TICK_DIV, default 50000: clock cycles per digit dwell tick, minimum 2.
REQ-003 Parameter GUARD_CYC, default 2: all-anodes-off cycles between digits, minimum 1.
REQ-004 Port clk_i, input, 1 bit: the single clock. All logic SHALL be clocked on its rising edge.
REQ-005 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port wr_valid_i, input, 1 bit: write request.
REQ-007 Port wr_ready_o, output, 1 bit: write accept.
REQ-008 Port wr_idx_i, input, 3 bits: target digit index.
REQ-009 Port wr_char_i, input, 8 bits: ASCII character for that digit.
REQ-010 Port commit_i, input, 1 bit: request to copy the shadow buffer to the active buffer.
REQ-011 Port commit_pend_o, output, 1 bit: a commit is pending.
REQ-012 Port blank_i, input, 1 bit: forces the display dark.
REQ-013 Port char_o, output, 8 bits: ASCII character to the 7-segment decoder.
REQ-014 Port an_o, output, NUM_DIG bits: digit enables, active-low.
REQ-015 Port frame_o, output, 1 bit: one-cycle pulse at each frame start.

Function
REQ-016 The prescaler SHALL count 0..TICK_DIV-1, pulse tick in the cycle it equals TICK_DIV-1, then wrap to 0; it runs only in S_SHOW and clears on entry to S_GUARD.
REQ-017 The FSM SHALL have two states, S_GUARD and S_SHOW.
REQ-018 S_GUARD SHALL drive an_o all ones and char_o 8'h20, and move to S_SHOW after GUARD_CYC cycles.
REQ-019 S_SHOW SHALL drive an_o[idx]=0, all other bits 1, and char_o=active[idx].
REQ-020 On tick in S_SHOW, the FSM SHALL advance idx by one and enter S_GUARD. idx wraps from NUM_DIG-1 to 0.
REQ-021 When idx wraps to 0, frame_o SHALL be 1 for exactly that cycle.
REQ-022 char_o and an_o SHALL be registered, change in the same cycle, and lag the state/idx change by one cycle.
REQ-023 A write SHALL occur when wr_valid_i & wr_ready_o: shadow[wr_idx_i] <= wr_char_i. Writes with wr_idx_i >= NUM_DIG SHALL be accepted and discarded.
REQ-024 wr_ready_o SHALL equal !commit_pend_o.
REQ-025 commit_i with no commit pending SHALL set commit_pend_o on the next cycle; commit_i while a commit is pending SHALL be ignored.
REQ-026 At the wrap cycle (REQ-021) with a commit pending, active SHALL be loaded from shadow in one cycle and commit_pend_o cleared. Display of digit 0 SHALL use the new contents.
REQ-027 Write and commit_i in the same cycle: the write SHALL land and be included in the commit.
REQ-028 blank_i=1 SHALL force an_o to all ones one cycle later. Scanning, writes and commits SHALL continue unaffected.
REQ-029 Active-buffer contents SHALL never change except at a frame wrap.

Reset
REQ-030 With rst_i high at a clock edge, the block SHALL set:
- shadow and active all 8'h20
- idx 0, state S_GUARD, prescaler 0
- an_o all ones, char_o 8'h20
- frame_o 0, commit_pend_o 0, wr_ready_o 1
REQ-031 Reset during a pending commit or mid-dwell SHALL discard the pending commit and all buffer contents, with no partial copy.

Structure
REQ-032 Package seg_pkg SHALL hold the state enum (S_GUARD, S_SHOW) and the constant BLANK_CHAR = 8'h20.
REQ-033 The prescaler SHALL be a sub-module, seg_tick_gen (ports clk_i, rst_i, en_i, tick_o, parameter TICK_DIV).
REQ-034 The 7-segment decoder SHALL NOT be instantiated inside this block; char_o feeds it externally.

Verification (NUM_DIG=4, TICK_DIV=4, GUARD_CYC=1)
REQ-035 Reset then idle: an_o cycles 1111,1110,1111,1101,1111,1011,1111,0111, with each enable held 4 cycles and char_o 8'h20 throughout. frame_o pulses every 20 cycles.
REQ-036 Write "1","2","3","4" to idx 0..3, then commit_i: commit_pend_o=1 and wr_ready_o=0 until the next wrap. Digits then show "1".."4", and char_o never shows "1".."4" before the wrap.
REQ-037 Write "A" to idx 2 in the same cycle as commit_i: after the wrap, digit 2 shows "A".
REQ-038 Second commit_i while pending, and a write with wr_idx_i=5: both are ignored, the buffer is unchanged, and the write handshake completes.
REQ-039 blank_i=1 for 10 cycles mid-scan: an_o=1111 for those cycles, offset by one, and the scan phase afterwards matches an unblanked reference count.
REQ-040 rst_i asserted during a pending commit: the next cycle shows all registers at their REQ-030 values, and a following frame shows 8'h20 on every digit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed display scanner.
package seg_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

endpackage

// File: rtl/seg_tick_gen.sv
// Dwell prescaler: counts while enabled, pulses on the last count, parks at 0 when disabled.
module seg_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_reg == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed display scanner with double-buffered character store.
// Shadow writes are committed to the active buffer only at a frame wrap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG   = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GUARD_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [2:0]         wr_idx_i,
  input  logic [7:0]         wr_char_i,
  input  logic               commit_i,
  output logic               commit_pend_o,
  input  logic               blank_i,
  output logic [7:0]         char_o,
  output logic [NUM_DIG-1:0] an_o,
  output logic               frame_o
);

  localparam int IW = $clog2(NUM_DIG);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);

  state_t             state_reg;
  logic [IW-1:0]      idx_reg;
  logic [GW-1:0]      guard_reg;
  logic               pend_reg;
  logic               frame_reg;
  logic [NUM_DIG-1:0] an_reg;
  logic [7:0]         char_reg;
  logic [7:0]         shadow_reg [NUM_DIG];
  logic [7:0]         active_reg [NUM_DIG];

  logic tick;
  logic wrap;
  logic wr_fire;
  logic show_en;

  assign show_en = (state_reg == S_SHOW);

  seg_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (show_en),
    .tick_o (tick)
  );

  // tick only fires in S_SHOW, so this marks the last digit's dwell ending
  assign wrap    = tick && (idx_reg == IDX_LAST);
  assign wr_fire = wr_valid_i && !pend_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_GUARD;
      idx_reg   <= '0;
      guard_reg <= '0;
      frame_reg <= 1'b0;
      an_reg    <= '1;
      char_reg  <= BLANK_CHAR;
    end else begin
      frame_reg <= wrap;
      case (state_reg)
        S_GUARD: begin
          if (guard_reg == GUARD_LAST) begin
            guard_reg <= '0;
            state_reg <= S_SHOW;
          end else begin
            guard_reg <= guard_reg + GW'(1);
          end
        end
        S_SHOW: begin
          if (tick) begin
            state_reg <= S_GUARD;
            idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
          end
        end
        default: state_reg <= S_GUARD;
      endcase
      // Outputs follow the current state/idx, giving a one-cycle lag
      if (state_reg == S_SHOW) begin
        an_reg   <= blank_i ? '1 : ~(NUM_DIG'(1) << idx_reg);
        char_reg <= active_reg[idx_reg];
      end else begin
        an_reg   <= '1;
        char_reg <= BLANK_CHAR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_reg <= 1'b0;
    end else if (wrap && pend_reg) begin
      pend_reg <= 1'b0;
    end else if (commit_i) begin
      pend_reg <= 1'b1;
    end
  end

  // Out-of-range indices match no digit, so such writes are simply dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow_reg[i] <= BLANK_CHAR;
        active_reg[i] <= BLANK_CHAR;
      end
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (wr_fire && (wr_idx_i == 3'(i))) begin
          shadow_reg[i] <= wr_char_i;
        end
        if (wrap && pend_reg) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  assign wr_ready_o    = !pend_reg;
  assign commit_pend_o = pend_reg;
  assign an_o          = an_reg;
  assign char_o        = char_reg;
  assign frame_o       = frame_reg;

endmodule
